// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared types and helpers for the pixel byte sender
package pixel_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hFF;
  localparam int MAX_PIXEL_W = 32;

  // Pixel field is sized for the widest supported pixel; unused MSBs are zero.
  typedef struct packed {
    logic                   sof;
    logic                   eof;
    logic [MAX_PIXEL_W-1:0] pixel;
  } fifo_entry_t;

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO with occupancy count, async active-low reset
module pixel_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - buffers pixels and sends them MSB-first as a byte stream with frame sync
// Optional trailing XOR checksum per frame: define PIXEL_STREAM_TX_CHECKSUM_EN.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int          PIXEL_W    = 12,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIXEL_W-1:0]            pixel_in,
  input  logic                          pixel_sof,
  input  logic                          pixel_eof,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int NBYTES = nbytes(PIXEL_W);
  localparam int REM_W  = PIXEL_W - 8 * (NBYTES - 1);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int WW     = MAX_PIXEL_W + 8;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [WW-1:0]    LAST_MASK = (WW'(1) << REM_W) - WW'(1);
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  fifo_entry_t      hold, hold_next, head, wr_entry;
  logic             pop, full, empty, ready_en;
  logic [7:0]       byte_next, csum_byte;
  logic             valid_next;

  // Leading bytes are taken from the top down; the last byte holds the leftover LSBs.
  function automatic logic [7:0] byte_at(input logic [MAX_PIXEL_W-1:0] p,
                                         input logic [IDX_W-1:0] k);
    logic [WW-1:0] w;
    int            sh;
    w  = {8'h00, p};
    sh = PIXEL_W - 8 - 8 * int'(k);
    if (int'(k) < NBYTES - 1) return 8'(w >> sh);
    else                      return 8'(w & LAST_MASK);
  endfunction

  assign wr_entry    = '{sof: pixel_sof, eof: pixel_eof, pixel: MAX_PIXEL_W'(pixel_in)};
  assign pixel_ready = ready_en && !full;
  assign busy        = (state != ST_IDLE) || !empty;

  pixel_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pixel_valid && pixel_ready),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      hold       <= '0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      hold       <= hold_next;
      byte_out   <= byte_next;
      byte_valid <= valid_next;
      ready_en   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          hold_next  = head;
          idx_next   = '0;
          state_next = head.sof ? ST_SYNC : ST_DATA;
        end
      end
      ST_SYNC: begin
        if (byte_ready) begin
          state_next = ST_DATA;
          idx_next   = '0;
        end
      end
      ST_DATA: begin
        if (byte_ready) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = (hold.eof && CSUM_EN) ? ST_CSUM : ST_IDLE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (byte_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A stalled byte is held verbatim; otherwise the next byte is precomputed into the output register.
  always_comb begin
    valid_next = (state_next != ST_IDLE);
    byte_next  = 8'h00;
    if (byte_valid && !byte_ready) begin
      byte_next = byte_out;
    end else begin
      case (state_next)
        ST_SYNC: byte_next = SYNC_BYTE;
        ST_DATA: byte_next = byte_at(hold_next.pixel, idx_next);
        ST_CSUM: byte_next = csum_byte;
        default: byte_next = 8'h00;
      endcase
    end
  end

`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
  logic [7:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 8'h00;
    end else if (byte_valid && byte_ready) begin
      if (state == ST_SYNC)      acc <= 8'h00;
      else if (state == ST_DATA) acc <= acc ^ byte_out;
    end
  end

  // Entered right as the last data byte goes out, so fold that byte in here.
  assign csum_byte = acc ^ byte_out;
`else
  assign csum_byte = 8'h00;
`endif

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - directed bench for pixel_stream_tx (default, 16-bit and 20-bit builds)
module tb_pixel_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_in;
  logic        pixel_sof, pixel_eof, pixel_valid, pixel_ready;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_ready, busy;
  logic [4:0]  fifo_count;

  logic [15:0] p16_pixel;
  logic        p16_valid, p16_ready, p16_bvalid, p16_busy;
  logic [7:0]  p16_byte;
  logic [4:0]  p16_count;
  logic [19:0] p20_pixel;
  logic        p20_valid, p20_ready, p20_bvalid, p20_busy;
  logic [7:0]  p20_byte;
  logic [4:0]  p20_count;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pixel_stream_tx dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_sof(pixel_sof), .pixel_eof(pixel_eof),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .fifo_count(fifo_count), .busy(busy)
  );

  pixel_stream_tx #(.PIXEL_W(16)) dut16 (
    .clk(clk), .rst(rst), .pixel_in(p16_pixel), .pixel_sof(1'b0), .pixel_eof(1'b0),
    .pixel_valid(p16_valid), .pixel_ready(p16_ready), .byte_out(p16_byte),
    .byte_valid(p16_bvalid), .byte_ready(byte_ready), .fifo_count(p16_count), .busy(p16_busy)
  );

  pixel_stream_tx #(.PIXEL_W(20)) dut20 (
    .clk(clk), .rst(rst), .pixel_in(p20_pixel), .pixel_sof(1'b0), .pixel_eof(1'b0),
    .pixel_valid(p20_valid), .pixel_ready(p20_ready), .byte_out(p20_byte),
    .byte_valid(p20_bvalid), .byte_ready(byte_ready), .fifo_count(p20_count), .busy(p20_busy)
  );

  typedef struct packed {
    logic [11:0] pix;
    logic        sof;
    logic        eof;
    logic [2:0]  n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] pix, input logic sof, input logic eof);
    pixel_in    = pix;
    pixel_sof   = sof;
    pixel_eof   = eof;
    pixel_valid = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  // Waits (bounded) for a valid byte and lets it transfer; byte_ready must be high.
  task automatic get_byte(output logic [7:0] b, output int waited, output bit ok);
    waited = 0;
    b      = 8'h00;
    while (!byte_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = byte_valid;
    if (ok) begin
      b = byte_out;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] e, q16, q20;
    logic [11:0] val;
    int          waited, maxgap, n16, n20;
    bit          ok, stable;

    vecs[0] = '{pix: 12'hABC, sof: 1'b1, eof: 1'b0, n: 3'd3, exp: 32'hFFAB0C00};
    vecs[1] = '{pix: 12'h123, sof: 1'b1, eof: 1'b0, n: 3'd3, exp: 32'hFF120300};
`ifdef PIXEL_STREAM_TX_CHECKSUM_EN
    vecs[2] = '{pix: 12'h456, sof: 1'b0, eof: 1'b1, n: 3'd3, exp: 32'h45065200};
    vecs[4] = '{pix: 12'hFFF, sof: 1'b1, eof: 1'b1, n: 3'd4, exp: 32'hFFFF0FF0};
    vecs[6] = '{pix: 12'h7FE, sof: 1'b1, eof: 1'b1, n: 3'd4, exp: 32'hFF7F0E71};
`else
    vecs[2] = '{pix: 12'h456, sof: 1'b0, eof: 1'b1, n: 3'd2, exp: 32'h45060000};
    vecs[4] = '{pix: 12'hFFF, sof: 1'b1, eof: 1'b1, n: 3'd3, exp: 32'hFFFF0F00};
    vecs[6] = '{pix: 12'h7FE, sof: 1'b1, eof: 1'b1, n: 3'd3, exp: 32'hFF7F0E00};
`endif
    vecs[3] = '{pix: 12'h000, sof: 1'b0, eof: 1'b0, n: 3'd2, exp: 32'h00000000};
    vecs[5] = '{pix: 12'h801, sof: 1'b1, eof: 1'b0, n: 3'd3, exp: 32'hFF800100};

    rst = 1'b0;
    pixel_in = '0; pixel_sof = 1'b0; pixel_eof = 1'b0; pixel_valid = 1'b0; byte_ready = 1'b0;
    p16_pixel = '0; p16_valid = 1'b0; p20_pixel = '0; p20_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_byte_out", 32'(byte_out), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pixel_ready", 32'(pixel_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_pixel_ready", 32'(pixel_ready), 1);
    check("post_rst_byte_valid", 32'(byte_valid), 0);
    check("p16_ready", 32'(p16_ready), 1);
    check("p20_ready", 32'(p20_ready), 1);
    check("p16_idle", 32'({p16_busy, p16_count}), 0);
    check("p20_idle", 32'({p20_busy, p20_count}), 0);

    byte_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      check("vec_pixel_ready", 32'(pixel_ready), 1);
      push(vecs[v].pix, vecs[v].sof, vecs[v].eof);
      e = vecs[v].exp;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        get_byte(b, waited, ok);
        check("vec_byte_arrived", 32'(ok), 1);
        check("vec_byte", 32'(b), 32'(e[31:24]));
        if (k == 0) check("vec_latency", 32'(waited <= 2), 1);
        e = e << 8;
      end
      check("vec_busy_after", 32'(busy), 0);
    end

    // Output stall mid-pixel
    push(12'h5A3, 1'b1, 1'b0);
    get_byte(b, waited, ok);
    check("stall_sync", 32'(b), 32'hFF);
    byte_ready = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!(byte_valid && byte_out == 8'h5A)) stable = 1'b0;
      @(negedge clk);
    end
    check("stall_hold_stable", 32'(stable), 1);
    byte_ready = 1'b1;
    get_byte(b, waited, ok);
    check("stall_byte0", 32'(b), 32'h5A);
    get_byte(b, waited, ok);
    check("stall_byte1", 32'(b), 32'h03);
    check("stall_busy_after", 32'(busy), 0);

    // FIFO full: first pixel sits in the holding register, 16 more fill the FIFO.
    byte_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pixel_in = 12'h300 + 12'(i); pixel_sof = (i == 0); pixel_eof = 1'b0; pixel_valid = 1'b1;
      @(negedge clk);
    end
    check("full_count", 32'(fifo_count), 16);
    check("full_pixel_ready", 32'(pixel_ready), 0);
    pixel_in = 12'hEEE; pixel_sof = 1'b0;
    repeat (3) @(negedge clk);
    pixel_valid = 1'b0;
    check("full_count_after_reject", 32'(fifo_count), 16);
    byte_ready = 1'b1;
    get_byte(b, waited, ok);
    check("full_sync", 32'(b), 32'hFF);
    maxgap = 0;
    for (int i = 0; i < 17; i++) begin
      val = 12'h300 + 12'(i);
      get_byte(b, waited, ok);
      if (i > 0 && waited > maxgap) maxgap = waited;
      check("full_hi", 32'(b), 32'(val[11:4]));
      get_byte(b, waited, ok);
      if (waited > maxgap) maxgap = waited;
      check("full_lo", 32'(b), 32'(val[3:0]));
    end
    check("full_gap", 32'(maxgap <= 1), 1);
    repeat (5) @(negedge clk);
    check("full_no_extra", 32'(byte_valid), 0);
    check("full_drained", 32'(fifo_count), 0);

    // Wider pixel builds
    p16_pixel = 16'h1234; p16_valid = 1'b1;
    p20_pixel = 20'hABCDE; p20_valid = 1'b1;
    @(negedge clk);
    p16_valid = 1'b0; p20_valid = 1'b0;
    q16 = '0; q20 = '0; n16 = 0; n20 = 0;
    for (int c = 0; c < 10; c++) begin
      if (p16_bvalid) begin q16 = (q16 << 8) | 32'(p16_byte); n16++; end
      if (p20_bvalid) begin q20 = (q20 << 8) | 32'(p20_byte); n20++; end
      @(negedge clk);
    end
    check("w16_count", 32'(n16), 2);
    check("w16_bytes", q16, 32'h1234);
    check("w20_count", 32'(n20), 3);
    check("w20_bytes", q20, 32'hABCD0E);

    // Reset during the second data byte
    push(12'h9C7, 1'b1, 1'b0);
    push(12'h135, 1'b0, 1'b0);
    get_byte(b, waited, ok);
    check("mid_sync", 32'(b), 32'hFF);
    get_byte(b, waited, ok);
    check("mid_byte0", 32'(b), 32'h9C);
    check("mid_byte1_pending", 32'({byte_valid, byte_out}), 32'h107);
    check("mid_fifo_before", 32'(fifo_count), 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(byte_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(12'h246, 1'b1, 1'b0);
    get_byte(b, waited, ok);
    check("after_rst_sync", 32'(b), 32'hFF);
    get_byte(b, waited, ok);
    check("after_rst_byte0", 32'(b), 32'h24);
    get_byte(b, waited, ok);
    check("after_rst_byte1", 32'(b), 32'h06);
    repeat (3) @(negedge clk);
    check("after_rst_quiet", 32'(byte_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
